// File: rtl/cp0_ctrl_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 exception/interrupt controller
// and the pipeline registers that use its handler address.
//   - CP0 register numbers (rd field of mfc0/mtc0)
//   - bit positions of the SR and Cause fields
//   - ExcCode values
//   - exception handler entry address
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR field positions
    localparam int unsigned SR_IE_BIT  = 0;
    localparam int unsigned SR_EXL_BIT = 1;
    localparam int unsigned SR_IM_LSB  = 10;
    localparam int unsigned SR_IM_MSB  = 15;

    // Cause field positions
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_EXC_MSB = 6;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_IP_MSB  = 15;
    localparam int unsigned CAUSE_BD_BIT  = 31;

    // Exception codes
    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // Handler entry point, loaded into the PC when req is taken
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 exception and interrupt controller at the M stage.
// Decides whether an exception or interrupt is taken (req), records Cause/EPC,
// and holds SR, Cause, EPC and PRId for mfc0 / mtc0 / eret.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   M_CP0_WE/Addr/WD  mtc0 write enable, register number, write data
//   M_PC, M_bd      victim PC and branch-delay flag of the M instruction
//   M_ExcCode       accumulated exception code (0 = none)
//   M_eret          eret in M, clears EXL
//   HWInt           level-sensitive external interrupt lines
//   CP0_RD          combinational read of register M_CP0_Addr
//   EPC_out         current EPC for the eret redirect
//   req             take exception/interrupt this cycle (combinational)
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_CP0_WE,
    input  logic [4:0]  M_CP0_Addr,
    input  logic [31:0] M_CP0_WD,
    input  logic [31:0] M_PC,
    input  logic        M_bd,
    input  logic [4:0]  M_ExcCode,
    input  logic        M_eret,
    input  logic [5:0]  HWInt,
    output logic [31:0] CP0_RD,
    output logic [31:0] EPC_out,
    output logic        req
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] rd_val;

    // Interrupt decision uses the live HWInt, not the registered Cause.IP.
    assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (M_ExcCode != 5'd0) & ~sr_exl;
    assign req     = (int_req | exc_req) & rst;

    assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (req) begin
                // The M instruction is flushed, so any mtc0/eret alongside is dropped.
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? EXC_INT : M_ExcCode;
                cause_bd  <= M_bd;
                epc       <= M_bd ? (M_PC - 32'd4) : M_PC;
            end else begin
                if (M_CP0_WE) begin
                    case (M_CP0_Addr)
                        REG_SR: begin
                            sr_im  <= M_CP0_WD[SR_IM_MSB:SR_IM_LSB];
                            sr_exl <= M_CP0_WD[SR_EXL_BIT];
                            sr_ie  <= M_CP0_WD[SR_IE_BIT];
                        end
                        REG_EPC: epc <= M_CP0_WD;
                        default: ;
                    endcase
                end
                // Placed after the write so eret wins on EXL if both appear.
                if (M_eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (M_CP0_Addr)
            REG_SR:    rd_val = sr_word;
            REG_CAUSE: rd_val = cause_word;
            REG_EPC:   rd_val = epc;
            REG_PRID:  rd_val = PRID;
            default:   rd_val = '0;
        endcase
    end

    // While rst is low the registers may still hold pre-reset values until the
    // edge, so reads are forced to their reset view.
    assign CP0_RD  = rst ? rd_val : ((M_CP0_Addr == REG_PRID) ? PRID : '0);
    assign EPC_out = rst ? epc : '0;

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

    localparam logic [31:0] PRID_VAL = 32'h2023_0007;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic [5:0]  hw;
    logic [31:0] cp0_rd;
    logic [31:0] epc_out;
    logic        req;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: architectural registers as full 32-bit words
    logic [31:0] m_sr = '0;
    logic [31:0] m_cause = '0;
    logic [31:0] m_epc = '0;

    cp0_ctrl #(.PRID(PRID_VAL)) dut (
        .clk        (clk),
        .rst        (rst),
        .M_CP0_WE   (we),
        .M_CP0_Addr (addr),
        .M_CP0_WD   (wd),
        .M_PC       (pc),
        .M_bd       (bd),
        .M_ExcCode  (exc),
        .M_eret     (eret),
        .HWInt      (hw),
        .CP0_RD     (cp0_rd),
        .EPC_out    (epc_out),
        .req        (req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic m_int_req();
        return (|(hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return rst && (m_int_req() || (exc != 5'd0 && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (!rst) return (a == 5'd15) ? PRID_VAL : 32'd0;
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_epc_out();
        return rst ? m_epc : 32'd0;
    endfunction

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic b, input logic [4:0] e,
                         input logic er, input logic [5:0] h);
        we = w; addr = a; wd = d; pc = p; bd = b; exc = e; eret = er; hw = h;
        #1;
    endtask

    // Advance one clock: model computes next state from the inputs held now.
    task automatic tick();
        logic [31:0] n_sr, n_cause, n_epc;
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
        if (!rst) begin
            n_sr = 0; n_cause = 0; n_epc = 0;
        end else begin
            if (m_req()) begin
                n_sr    = m_sr | 32'h2;
                n_epc   = bd ? pc - 32'd4 : pc;
                n_cause = (32'(bd) << 31) | ((m_int_req() ? 32'd0 : 32'(exc)) << 2);
            end else begin
                if (we && addr == 5'd12) n_sr = wd & 32'h0000_FC03;
                if (we && addr == 5'd14) n_epc = wd;
                if (eret) n_sr = n_sr & ~32'h2;
            end
            n_cause = (n_cause & ~32'h0000_FC00) | (32'(hw) << 10);
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 5'd5, 1'b0, 6'h3F);
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        tick();
        tick();
        for (int i = 12; i <= 15; i++) begin
            drive(1'b0, 5'(i), 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
            checks++;
            if (cp0_rd !== m_read(5'(i))) begin
                errors++; $display("FAIL reset_read%0d: got %h want %h", i, cp0_rd, m_read(5'(i)));
            end
        end
        checks++;
        if (cp0_rd !== 32'h2023_0007) begin errors++; $display("FAIL reset_prid: got %h want 20230007", cp0_rd); end
        checks++;
        if (epc_out !== 32'd0) begin errors++; $display("FAIL reset_epc_out: got %h want 0", epc_out); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_interrupt();
        drive(1'b1, 5'd12, 32'h0000_FC01, 32'h0000_1000, 1'b0, 5'd0, 1'b0, 6'd0);
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL int_mtc0_req: got %b want 0", req); end
        tick();
        drive(1'b0, 5'd13, 32'd0, 32'h0000_1000, 1'b0, 5'd0, 1'b0, 6'b000100);
        checks++;
        if (req !== 1'b1 || m_req() !== 1'b1) begin errors++; $display("FAIL int_req: got %b want 1", req); end
        tick();
        drive(1'b0, 5'd13, 32'd0, 32'h0000_1004, 1'b0, 5'd0, 1'b0, 6'b000100);
        checks++;
        if (cp0_rd !== 32'h0000_1000 || m_read(5'd13) !== 32'h0000_1000) begin
            errors++; $display("FAIL int_cause: got %h want 00001000", cp0_rd);
        end
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL int_exl_mask: got %b want 0", req); end
        addr = 5'd12; #1;
        checks++;
        if (cp0_rd !== m_read(5'd12)) begin errors++; $display("FAIL int_sr: got %h want %h", cp0_rd, m_read(5'd12)); end
        checks++;
        if (epc_out !== 32'h0000_1000) begin errors++; $display("FAIL int_epc: got %h want 00001000", epc_out); end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
        tick();
    endtask

    task automatic test_exception_bd();
        drive(1'b0, 5'd14, 32'd0, 32'h0000_3008, 1'b1, 5'd12, 1'b0, 6'd0);
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b want 1", req); end
        tick();
        drive(1'b0, 5'd14, 32'd0, 32'h0000_4180, 1'b0, 5'd0, 1'b0, 6'd0);
        checks++;
        if (cp0_rd !== 32'h0000_3004) begin errors++; $display("FAIL exc_bd_epc: got %h want 00003004", cp0_rd); end
        addr = 5'd13; #1;
        checks++;
        if (cp0_rd !== 32'h8000_0030 || m_read(5'd13) !== 32'h8000_0030) begin
            errors++; $display("FAIL exc_bd_cause: got %h want 80000030", cp0_rd);
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
        tick();
    endtask

    task automatic test_exl_mask_eret();
        drive(1'b0, 5'd0, 32'd0, 32'h0000_2000, 1'b0, 5'd4, 1'b0, 6'd0);
        tick();
        drive(1'b0, 5'd13, 32'd0, 32'h0000_4180, 1'b0, 5'd10, 1'b0, 6'b000100);
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL exl_mask_req: got %b want 0", req); end
        tick();
        drive(1'b0, 5'd13, 32'd0, 32'h0000_4184, 1'b0, 5'd0, 1'b1, 6'b000100);
        checks++;
        if (cp0_rd[6:2] !== 5'd4 || cp0_rd !== m_read(5'd13)) begin
            errors++; $display("FAIL exl_mask_cause: got %h want %h", cp0_rd, m_read(5'd13));
        end
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL eret_cycle_req: got %b want 0", req); end
        tick();
        drive(1'b0, 5'd12, 32'd0, 32'h0000_2000, 1'b0, 5'd0, 1'b0, 6'b000100);
        checks++;
        if (req !== 1'b1 || m_req() !== 1'b1) begin errors++; $display("FAIL post_eret_req: got %b want 1", req); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
        tick();
    endtask

    task automatic test_mtc0_drop();
        drive(1'b1, 5'd14, 32'h0000_3100, 32'h0000_3200, 1'b0, 5'd4, 1'b0, 6'd0);
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL drop_req: got %b want 1", req); end
        tick();
        drive(1'b0, 5'd14, 32'd0, 32'h0000_4180, 1'b0, 5'd0, 1'b0, 6'd0);
        checks++;
        if (cp0_rd !== 32'h0000_3200 || epc_out !== 32'h0000_3200) begin
            errors++; $display("FAIL drop_epc: got %h/%h want 00003200", cp0_rd, epc_out);
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
        tick();
    endtask

    task automatic test_int_exc_reset();
        drive(1'b0, 5'd13, 32'd0, 32'h0000_0500, 1'b0, 5'd5, 1'b0, 6'b000001);
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL intexc_req: got %b want 1", req); end
        tick();
        drive(1'b0, 5'd13, 32'd0, 32'h0000_4180, 1'b0, 5'd0, 1'b0, 6'b000001);
        checks++;
        if (cp0_rd !== 32'h0000_0400 || m_read(5'd13) !== 32'h0000_0400) begin
            errors++; $display("FAIL intexc_cause: got %h want 00000400", cp0_rd);
        end
        rst = 1'b0;
        drive(1'b0, 5'd14, 32'd0, 32'h0000_4180, 1'b0, 5'd6, 1'b0, 6'b111111);
        checks++;
        if (req !== 1'b0 || epc_out !== 32'd0) begin
            errors++; $display("FAIL midreset_out: got req=%b epc=%h want 0/0", req, epc_out);
        end
        tick();
        rst = 1'b1;
        for (int i = 12; i <= 15; i++) begin
            drive(1'b0, 5'(i), 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
            checks++;
            if (cp0_rd !== m_read(5'(i))) begin
                errors++; $display("FAIL midreset_read%0d: got %h want %h", i, cp0_rd, m_read(5'(i)));
            end
        end
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b want 0", req); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a;
            rst = ($urandom_range(0, 39) != 0);
            a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            drive(($urandom_range(0, 3) == 0), a, $urandom, $urandom,
                  1'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0);
            checks++;
            if (req !== m_req()) begin errors++; $display("FAIL rand_req[%0d]: got %b want %b", n, req, m_req()); end
            checks++;
            if (cp0_rd !== m_read(a)) begin
                errors++; $display("FAIL rand_rd[%0d] addr %0d: got %h want %h", n, a, cp0_rd, m_read(a));
            end
            checks++;
            if (epc_out !== m_epc_out()) begin
                errors++; $display("FAIL rand_epc_out[%0d]: got %h want %h", n, epc_out, m_epc_out());
            end
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; addr = '0; wd = '0; pc = '0; bd = 1'b0;
        exc = '0; eret = 1'b0; hw = '0;
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_exl_mask_eret();
        test_mtc0_drop();
        test_int_exc_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
